instr_fetch_unit: RTL and testbench

Fetch-side initiator for the combinational instruction ROM. Owns the program counter, drives a 64-bit byte address to the ROM every cycle, and captures each returned 32-bit word into a 2-entry prefetch buffer. Presents instructions to decode through a valid/ready handshake and accepts branch redirects from execute.

---
 rtl/fetch_pkg.sv | 12 +
 rtl/instr_fetch_unit_if.sv | 26 ++
 rtl/fetch_buffer.sv | 52 +++++
 rtl/instr_fetch_unit.sv | 89 ++++++++
 tb/tb_instr_fetch_unit.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and sizing for the instruction fetch unit.
package fetch_pkg;
  localparam int FETCH_DEPTH = 2;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {IDLE, RUN, HALT} fetch_state_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// ROM, decode and redirect signals of the fetch unit; master = fetch unit side.
interface instr_fetch_unit_if;
  logic [63:0] fetch_addr;
  logic [31:0] fetch_instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        fault;

  modport master (
    output fetch_addr, input fetch_instr,
    output instr_valid, input instr_ready, output instr, output instr_pc,
    input redirect_valid, input redirect_pc,
    output fault
  );

  modport slave (
    input fetch_addr, output fetch_instr,
    input instr_valid, output instr_ready, input instr, input instr_pc,
    output redirect_valid, output redirect_pc,
    input fault
  );
endinterface

// File: rtl/fetch_buffer.sv
// Two-entry in-order prefetch FIFO; entry 0 is always the head.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_data,
  output fetch_entry_t head,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);
  fetch_entry_t [FETCH_DEPTH-1:0] ent_q, ent_d;
  logic [1:0] count_q, count_d;
  logic       pop_ok, push_ok;
  logic [1:0] wr_idx;

  assign empty   = (count_q == 2'd0);
  assign full    = (count_q == 2'(FETCH_DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign wr_idx  = count_q - {1'b0, pop_ok};

  always_comb begin
    ent_d   = ent_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      // Shift only from a full buffer so an emptied head keeps its last word.
      if (pop_ok && full) ent_d[0] = ent_q[1];
      if (push_ok) ent_d[wr_idx[0]] = wr_data;
      count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ent_q   <= '0;
      count_q <= 2'd0;
    end else begin
      ent_q   <= ent_d;
      count_q <= count_d;
    end
  end

  assign head  = ent_q[0];
  assign count = count_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// PC, fetch FSM and fire logic in front of a combinational instruction ROM.
// Optional FETCH_FAULT_EN: halt with fault on misaligned/out-of-range pc.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 1024,
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input logic               clk,
  input logic               reset_n,
  instr_fetch_unit_if.master bus
);
  fetch_state_t state_q, state_d;
  logic [63:0]  pc_q, pc_d, redir_tgt;
  logic         fault_q, fault_d;
  logic         redirect_act, pop_raw, room, want, bad, fire, fault_hit;
  fetch_entry_t head;
  logic [1:0]   buf_count;
  logic         buf_full, buf_empty;

  assign redirect_act = bus.redirect_valid && (state_q != IDLE);
  assign pop_raw      = bus.instr_valid && bus.instr_ready;
  assign room         = (buf_count < 2'(FETCH_DEPTH)) || (buf_full && pop_raw);
  assign want         = (state_q == RUN) && room && !redirect_act;

`ifdef FETCH_FAULT_EN
  assign bad           = (pc_q[1:0] != 2'b00) || (pc_q + 64'd3 >= 64'(MEM_SIZE));
  assign redir_tgt     = bus.redirect_pc;
  assign bus.fetch_addr = pc_q;
`else
  assign bad           = 1'b0;
  assign redir_tgt     = {bus.redirect_pc[63:2], 2'b00};
  assign bus.fetch_addr = pc_q & 64'(MEM_SIZE - 1);
`endif

  assign fire      = want && !bad;
  assign fault_hit = want && bad;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    case (state_q)
      IDLE:    state_d = RUN;
      RUN:     if (fault_hit) begin
                 state_d = HALT;
                 fault_d = 1'b1;
               end
      default: ;
    endcase
    if (fire) pc_d = pc_q + 64'(INSTR_BYTES);
    // Redirect wins over everything, including a same-cycle fetch or fault.
    if (redirect_act) begin
      state_d = RUN;
      pc_d    = redir_tgt;
      fault_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  fetch_buffer u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fire),
    .pop     (pop_raw && !redirect_act),
    .flush   (redirect_act),
    .wr_data ('{pc: pc_q, instr: bus.fetch_instr}),
    .head    (head),
    .count   (buf_count),
    .full    (buf_full),
    .empty   (buf_empty)
  );

  assign bus.instr_valid = !buf_empty;
  assign bus.instr       = head.instr;
  assign bus.instr_pc    = head.pc;
  assign bus.fault       = fault_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; ROM word at byte addr a is 0xA0 + a/4.
module tb_instr_fetch_unit;
  logic clk, reset_n;
  int   n_chk = 0, n_pass = 0;

  instr_fetch_unit_if ifc ();

  instr_fetch_unit #(.MEM_SIZE(1024), .RESET_PC(64'd0)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc)
  );

  assign ifc.fetch_instr = 32'h0000_00A0 + {2'b00, ifc.fetch_addr[31:2]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    ifc.instr_ready    = 1'b1;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc    = 64'd0;
    #1;
    chk("rst_addr",  ifc.fetch_addr, 64'd0);
    chk("rst_valid", ifc.instr_valid, 0);
    chk("rst_instr", ifc.instr, 0);
    chk("rst_pc",    ifc.instr_pc, 0);
    chk("rst_fault", ifc.fault, 0);
    #1 reset_n = 1'b1;

    // Streaming with ready held high.
    step;  // cycle 1
    chk("c1_valid", ifc.instr_valid, 0);
    chk("c1_addr",  ifc.fetch_addr, 64'd0);
    step;  // cycle 2
    chk("c2_valid", ifc.instr_valid, 1);
    chk("c2_pc",    ifc.instr_pc, 64'd0);
    chk("c2_instr", ifc.instr, 32'hA0);
    for (int i = 1; i < 4; i++) begin
      step;
      chk("stream_valid", ifc.instr_valid, 1);
      chk("stream_pc",    ifc.instr_pc, 64'(4 * i));
      chk("stream_instr", ifc.instr, 32'hA0 + 32'(i));
    end

    // Backpressure: ready low from the first valid cycle.
    reset_n = 1'b0;
    ifc.instr_ready = 1'b0;
    #1 reset_n = 1'b1;
    step; step;  // cycle 2
    chk("bp_first_pc", ifc.instr_pc, 64'd0);
    repeat (5) step;  // cycle 7
    chk("bp_addr",  ifc.fetch_addr, 64'd8);
    chk("bp_valid", ifc.instr_valid, 1);
    chk("bp_head",  ifc.instr_pc, 64'd0);
    ifc.instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_drain_pc",    ifc.instr_pc, 64'(4 * i));
      chk("bp_drain_instr", ifc.instr, 32'hA0 + 32'(i));
      if (i < 3) step;
    end

    // cycle 10: head pc=12, count=2, pop this cycle plus redirect.
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 64'h40;
    step;
    ifc.redirect_valid = 1'b0;
    chk("rd_flush_valid", ifc.instr_valid, 0);
    chk("rd_addr",        ifc.fetch_addr, 64'h40);
    step;
    chk("rd_valid", ifc.instr_valid, 1);
    chk("rd_pc",    ifc.instr_pc, 64'h40);
    chk("rd_instr", ifc.instr, 32'hB0);
    step;
    chk("rd_next_pc", ifc.instr_pc, 64'h44);

    // Misaligned redirect.
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 64'h42;
    step;
    ifc.redirect_valid = 1'b0;
    chk("mis_valid0", ifc.instr_valid, 0);
`ifdef FETCH_FAULT_EN
    chk("mis_addr", ifc.fetch_addr, 64'h42);
    step;
    chk("mis_fault", ifc.fault, 1);
    chk("mis_valid", ifc.instr_valid, 0);

    // Run up to the end of the ROM.
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 64'd1012;
    step;
    ifc.redirect_valid = 1'b0;
    chk("end_fault_clr", ifc.fault, 0);
    step;
    chk("end_pc0", ifc.instr_pc, 64'd1012);
    step; step;
    chk("end_pc_last", ifc.instr_pc, 64'd1020);
    chk("end_instr",   ifc.instr, 32'hA0 + 32'd255);
    step;
    chk("end_fault", ifc.fault, 1);
    chk("end_valid", ifc.instr_valid, 0);
    chk("end_addr",  ifc.fetch_addr, 64'd1024);
    step;
    chk("end_addr_held", ifc.fetch_addr, 64'd1024);
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 64'd0;
    step;
    ifc.redirect_valid = 1'b0;
    chk("resume_fault", ifc.fault, 0);
    chk("resume_addr",  ifc.fetch_addr, 64'd0);
    step;
    chk("resume_pc", ifc.instr_pc, 64'd0);
`else
    chk("mis_addr", ifc.fetch_addr, 64'h40);
    step;
    chk("mis_valid", ifc.instr_valid, 1);
    chk("mis_pc",    ifc.instr_pc, 64'h40);
    chk("mis_fault", ifc.fault, 0);

    // Address wrap at the top of the ROM.
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 64'h3FC;
    step;
    ifc.redirect_valid = 1'b0;
    chk("wrap_addr0", ifc.fetch_addr, 64'h3FC);
    step;
    chk("wrap_pc0",   ifc.instr_pc, 64'h3FC);
    chk("wrap_instr0", ifc.instr, 32'h19F);
    chk("wrap_addr1", ifc.fetch_addr, 64'd0);
    step;
    chk("wrap_pc1",    ifc.instr_pc, 64'h400);
    chk("wrap_instr1", ifc.instr, 32'hA0);
`endif

    // Fill the buffer, then reset asynchronously mid-cycle.
    ifc.instr_ready = 1'b0;
    repeat (3) step;
    chk("pre_rst_valid", ifc.instr_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_valid", ifc.instr_valid, 0);
    chk("async_addr",  ifc.fetch_addr, 64'd0);
    chk("async_fault", ifc.fault, 0);
    chk("async_pc",    ifc.instr_pc, 64'd0);
    #1 reset_n = 1'b1;
    step; step;
    chk("post_rst_pc", ifc.instr_pc, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
